// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants and helpers for the RV32M multiply/divide sequencer.
// Holds the M-extension func3/func7 codes and the operand-signedness decode.
package muldiv_sequencer_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef struct packed {
      logic a_signed;
      logic b_signed;
   } sign_flags_t;

   // MULH/DIV/REM: both signed; MULHSU: only rs1 signed; everything else unsigned.
   function automatic sign_flags_t decode_signs(input logic [2:0] f3);
      sign_flags_t sf;
      case (f3)
         F3_MULH, F3_DIV, F3_REM: begin
            sf.a_signed = 1'b1;
            sf.b_signed = 1'b1;
         end
         F3_MULHSU: begin
            sf.a_signed = 1'b1;
            sf.b_signed = 1'b0;
         end
         default: begin
            sf.a_signed = 1'b0;
            sf.b_signed = 1'b0;
         end
      endcase
      return sf;
   endfunction

endpackage

// File: rtl/muldiv_sequencer_abs.sv
// Conditional two's-complement negate; used for operand magnitudes and
// for restoring the sign of the product/quotient/remainder.
module muldiv_sequencer_abs #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         negate,
   output logic [W-1:0] result
);

   // Negate the input when requested, otherwise pass it through.
   always_comb begin
      if (negate) begin
         result = ~value + W'(1);
      end else begin
         result = value;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit with its sequencing FSM.
// Optional build macro: MULDIV_EARLY_OUT_EN lets MUL finish as soon as the
// remaining multiplier is zero (minimum one iteration).
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]        state, next_state;
   logic [2:0]        op;
   logic              neg_res, neg_rem;
   logic [2*XLEN-1:0] acc, mcand;
   logic [XLEN-1:0]   opb;
   logic [CNT_W-1:0]  cnt;

   sign_flags_t       sf;
   logic              sign_a, sign_b, accept, is_special;
   logic              cnt_last, mul_last;
   logic [XLEN-1:0]   abs_a, abs_b, special_val, fix_val;
   logic [XLEN-1:0]   quo_fix, rem_fix;
   logic [2*XLEN-1:0] prod_fix, div_next;
   logic [XLEN:0]     div_hi;

   assign sf       = decode_signs(func3);
   assign sign_a   = sf.a_signed & rs1[XLEN-1];
   assign sign_b   = sf.b_signed & rs2[XLEN-1];
   assign accept   = (state == S_IDLE) & start & ~flush;
   assign cnt_last = (cnt == CNT_W'(XLEN - 1));

`ifdef MULDIV_EARLY_OUT_EN
   assign mul_last = cnt_last | (opb[XLEN-1:1] == '0);
`else
   assign mul_last = cnt_last;
`endif

   muldiv_sequencer_abs #(.W(XLEN))   u_abs_a (.value(rs1), .negate(sign_a), .result(abs_a));
   muldiv_sequencer_abs #(.W(XLEN))   u_abs_b (.value(rs2), .negate(sign_b), .result(abs_b));
   muldiv_sequencer_abs #(.W(2*XLEN)) u_prod  (.value(acc), .negate(neg_res), .result(prod_fix));
   muldiv_sequencer_abs #(.W(XLEN))   u_quo   (.value(acc[XLEN-1:0]), .negate(neg_res), .result(quo_fix));
   muldiv_sequencer_abs #(.W(XLEN))   u_rem   (.value(acc[2*XLEN-1:XLEN]), .negate(neg_rem), .result(rem_fix));

   // Divide-by-zero and signed-overflow short-circuit detection on live operands.
   always_comb begin
      is_special  = 1'b0;
      special_val = '0;
      if (func3[2] && (rs2 == '0)) begin
         is_special  = 1'b1;
         special_val = func3[1] ? rs1 : '1;
      end else if (func3[2] && !func3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1)) begin
         is_special  = 1'b1;
         special_val = func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end else begin
         is_special  = 1'b0;
         special_val = '0;
      end
   end

   // One restoring-division step: shift {rem,quo} left, subtract divisor if it fits.
   always_comb begin
      div_hi = acc[2*XLEN-1:XLEN-1];
      if (div_hi >= {1'b0, opb}) begin
         div_next = {div_hi[XLEN-1:0] - opb, acc[XLEN-2:0], 1'b1};
      end else begin
         div_next = {div_hi[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
   end

   // Sign-corrected result selection for the FIX state.
   always_comb begin
      case (op)
         F3_MUL:                       fix_val = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              fix_val = quo_fix;
         default:                      fix_val = rem_fix;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; a flush in any busy state wins over normal sequencing.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (!accept)        next_state = S_IDLE;
            else if (!func3[2]) next_state = S_MUL;
            else if (is_special) next_state = S_DONE;
            else                next_state = S_DIV;
         end
         S_MUL:   next_state = mul_last ? S_FIX : S_MUL;
         S_DIV:   next_state = cnt_last ? S_FIX : S_DIV;
         S_FIX:   next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
      if (flush && (state != S_IDLE)) begin
         next_state = S_IDLE;
      end else begin
         next_state = next_state;
      end
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy  = (state != S_IDLE);
      done  = (state == S_DONE);
      stall = busy | (start & ~flush);
   end

   // Datapath: operand capture, iteration, and result write-back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op      <= 3'b000;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         acc     <= '0;
         mcand   <= '0;
         opb     <= '0;
         cnt     <= '0;
         result  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op      <= func3;
                  neg_res <= sign_a ^ sign_b;
                  neg_rem <= sign_a;
                  opb     <= abs_b;
                  cnt     <= '0;
                  if (!func3[2]) begin
                     mcand <= {{XLEN{1'b0}}, abs_a};
                     acc   <= '0;
                  end else begin
                     mcand <= '0;
                     acc   <= {{XLEN{1'b0}}, abs_a};
                  end
                  if (is_special) begin
                     result <= special_val;
                  end
               end
            end
            S_MUL: begin
               if (opb[0]) begin
                  acc <= acc + mcand;
               end
               mcand <= mcand << 1;
               opb   <= opb >> 1;
               cnt   <= cnt + CNT_W'(1);
            end
            S_DIV: begin
               acc <= div_next;
               cnt <= cnt + CNT_W'(1);
            end
            S_FIX: begin
               if (!flush) begin
                  result <= fix_val;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative RV32M multiply/divide unit and its sequencing FSM. It sits beside the main ALU in the EX stage and is selected when `OPCODE_Arith_R` is decoded with func7 = 0000001. It accepts one operation per start pulse and stalls the pipeline while busy. It returns a 32-bit result with a one-cycle done pulse.

Parameters:
XLEN, 32, operand/result width.
CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
start  in  1  request; sampled only in IDLE
flush  in  1  abort current op (pipeline flush)
func3  in  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  in  XLEN  operand A
rs2  in  XLEN  operand B
busy  out  1  high in every state except IDLE
stall  out  1  busy | (start & ~flush); holds the front-end
done  out  1  one-cycle pulse; result valid that cycle
result  out  XLEN  final value, held until next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, counter=0, internal acc/quotient/remainder=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start & ~flush latches func3, sign flags, and |rs1|, |rs2|.
  - Signedness: MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 as signed, rs2 as unsigned; others unsigned.
  - Next state: MUL if func3[2]=0; otherwise DIV, or DONE on a special case.
- Special cases, decided in IDLE, go to DONE next cycle (done at cycle 1):
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): DIV result = 0x80000000; REM result = 0.
- MUL: shift-add, one multiplier bit per cycle, XLEN cycles; 2*XLEN-bit accumulator.
- DIV: restoring division, one quotient bit per cycle, XLEN cycles.
- FIX (1 cycle):
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
  - MUL selects the low XLEN bits; MULH/MULHSU/MULHU select the high XLEN bits.
  - Writes result.
- DONE: done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- Latency: start at cycle 0; iterations in cycles 1..32; FIX at cycle 33; done at cycle 34.
- start while busy is ignored (no queueing).
- flush in any non-IDLE state forces IDLE next cycle. No done is raised and result is unchanged.
- If flush and start arrive together in IDLE, flush wins and nothing is accepted.
- Operands are captured at start; later changes to rs1/rs2/func3 have no effect.
- Reset mid-operation returns to IDLE immediately with all outputs cleared.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: MUL state exits to FIX as soon as the remaining shifted multiplier is zero, with a minimum of 1 iteration. Latency = index of the highest set bit of |rs2| + 3; rs2=0 gives latency 3.
- Undefined: MUL always runs XLEN iterations (fixed latency 34).
- DIV latency is unaffected in both cases.

Decomposition:
- Add F3_MUL..F3_REMU and F7_MULDIV (7'b0000001) to definesms3.vh alongside the existing F3_/OPCODE_ constants.
- State encodings stay local localparams.
- No sub-module required; an optional muldiv_abs (combinational conditional two's-complement negate) may be shared by operand capture and FIX.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> done at cycle 34, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF.
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=-1, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done at cycle 1; DIV 0x80000000/-1 -> 0x80000000 and REM -> 0, both with done at cycle 1.
- flush at cycle 10 of a DIV -> IDLE at cycle 11, no done, result keeps prior value. A start asserted while busy is ignored.
- With MULDIV_EARLY_OUT_EN: MUL 9*3 -> result 27, done at cycle 4. rst asserted mid-MUL -> busy=0 and result=0 immediately.
